// File: rtl/tx_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_channel_arbiter
// Purpose  : Round-robin arbiter that shares one serial transmitter between
//            four requesters. It grants one requester, loads its byte into
//            the serializer, waits for link-ready, starts the send, and then
//            waits for the stop-bit pulse or a timeout.
// Ports    : clock     - sole clock, rising edge
//            reset     - synchronous, active-high
//            req       - per-requester transmit request (level)
//            data_bus  - requester k byte at [8k+7:8k]
//            dsr       - link ready, required before a send
//            tx_end    - stop-bit-sent pulse from the serializer
//            grant     - one-hot owner of the serializer, 0 when idle
//            tx_load   - one-cycle load strobe
//            tx_data   - byte of the granted requester
//            tx_send   - one-cycle start strobe
//            confirm   - one-cycle completion pulse
//            error     - sticky fault flag (dsr low at check, or timeout)
//            busy      - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module tx_channel_arbiter #(
    parameter int TIMEOUT = 1200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] data_bus,
    input  logic        dsr,
    input  logic        tx_end,
    output logic [3:0]  grant,
    output logic        tx_load,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    output logic        confirm,
    output logic        error,
    output logic        busy
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_LOAD     = 3'd1;
    localparam logic [2:0] c_CHECK    = 3'd2;
    localparam logic [2:0] c_SEND     = 3'd3;
    localparam logic [2:0] c_WAIT_END = 3'd4;
    localparam logic [2:0] c_DONE     = 3'd5;

    // Last WAIT_END count value before the transfer is declared lost.
    localparam logic [10:0] c_WAIT_LAST = 11'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [1:0]  r_ptr;
    logic [1:0]  r_idx;
    logic [10:0] r_wait_cnt;

    logic        w_found;
    logic [1:0]  w_sel;

    // Rotating priority search starting at r_ptr; the 2-bit index wraps
    // naturally so ptr, ptr+1, ... covers all four requesters mod 4.
    always_comb begin
        logic [1:0] k;
        w_found = 1'b0;
        w_sel   = r_ptr;
        k       = r_ptr;
        for (int i = 0; i < 4; i++) begin
            k = r_ptr + 2'(i);
            if (!w_found && req[k]) begin
                w_found = 1'b1;
                w_sel   = k;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_ptr      <= 2'd0;
            r_idx      <= 2'd0;
            r_wait_cnt <= 11'd0;
            grant      <= 4'd0;
            tx_data    <= 8'd0;
            tx_load    <= 1'b0;
            tx_send    <= 1'b0;
            confirm    <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a transition below re-asserts them.
            tx_load <= 1'b0;
            tx_send <= 1'b0;
            confirm <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_state <= c_LOAD;
                        r_idx   <= w_sel;
                        grant   <= 4'b0001 << w_sel;
                        tx_data <= data_bus[{w_sel, 3'b000} +: 8];
                        tx_load <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                c_LOAD: begin
                    r_state <= c_CHECK;
                end
                c_CHECK: begin
                    if (dsr) begin
                        r_state <= c_SEND;
                        tx_send <= 1'b1;
                    end else begin
                        error <= 1'b1;
                    end
                end
                c_SEND: begin
                    r_state    <= c_WAIT_END;
                    r_wait_cnt <= 11'd0;
                end
                c_WAIT_END: begin
                    // tx_end is checked first so it wins over a coincident timeout.
                    if (tx_end) begin
                        r_state <= c_DONE;
                        confirm <= 1'b1;
                        error   <= 1'b0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state <= c_IDLE;
                        error   <= 1'b1;
                        grant   <= 4'd0;
                        busy    <= 1'b0;
                        r_ptr   <= r_idx + 2'd1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 11'd1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    grant   <= 4'd0;
                    busy    <= 1'b0;
                    r_ptr   <= r_idx + 2'd1;
                end
                default: begin
                    r_state <= c_IDLE;
                    grant   <= 4'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_channel_arbiter
// Purpose  : Self-checking bench for tx_channel_arbiter. A vector table drives
//            complete transfers; expected grant/byte pairs go into a queue
//            and are popped when the DUT raises tx_load. Hand-written
//            sequences cover timeout and reset-during-transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_channel_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_bus;
    logic        dsr;
    logic        tx_end;
    logic [3:0]  grant;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        confirm;
    logic        error;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    tx_channel_arbiter #(.TIMEOUT(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .data_bus (data_bus),
        .dsr      (dsr),
        .tx_end   (tx_end),
        .grant    (grant),
        .tx_load  (tx_load),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .confirm  (confirm),
        .error    (error),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          stall;
        int          waitc;
        bit          drop;
        bit          rst_first;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_data;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
    } sb_t;

    vec_t vecs[10];
    sb_t  exp_q[$];
    sb_t  mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"},   grant,   0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_tx_load"}, tx_load, 0);
        chk({tag, "_tx_send"}, tx_send, 0);
        chk({tag, "_confirm"}, confirm, 0);
        chk({tag, "_error"},   error,   0);
        chk({tag, "_busy"},    busy,    0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req    = 4'd0;
        dsr    = 1'b0;
        tx_end = 1'b0;
        step();
        step();
        reset  = 1'b0;
    endtask

    // One complete transfer: grant, optional dsr stall, optional extra
    // WAIT_END cycles, then a tx_end pulse and the return to idle.
    task automatic do_xfer(input logic [3:0] r, input logic [31:0] d, input int stall,
                           input int waitc, input bit drop,
                           input logic [3:0] eg, input logic [7:0] ed);
        sb_t e;
        e.g = eg;
        e.d = ed;
        exp_q.push_back(e);
        req      = r;
        data_bus = d;
        dsr      = (stall == 0);
        tx_end   = 1'b0;
        step();
        chk("load_strobe", tx_load, 1);
        chk("load_busy",   busy,    1);
        chk("load_grant",  grant,   eg);
        if (drop) req = 4'd0;
        step();
        chk("check_no_load", tx_load, 0);
        chk("check_no_send", tx_send, 0);
        for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_no_send", tx_send, 0);
            chk("stall_error",   error,   1);
        end
        dsr = 1'b1;
        step();
        chk("send_strobe", tx_send, 1);
        chk("send_grant",  grant,   eg);
        step();
        chk("wait_no_send", tx_send, 0);
        for (int w = 0; w < waitc; w++) begin
            step();
            chk("wait_busy",       busy,    1);
            chk("wait_no_confirm", confirm, 0);
        end
        tx_end = 1'b1;
        step();
        tx_end = 1'b0;
        chk("done_confirm", confirm, 1);
        chk("done_error",   error,   0);
        chk("done_grant",   grant,   eg);
        chk("done_data",    tx_data, ed);
        step();
        chk("idle_confirm", confirm, 0);
        chk("idle_busy",    busy,    0);
        chk("idle_grant",   grant,   0);
    endtask

    // Scoreboard: every load strobe must match the oldest pending expectation.
    always @(negedge clock) begin
        if (tx_load === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_load: tx_load=1 grant=%0h with no transfer pending", grant);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_grant", grant,   mon_e.g);
                chk("sb_data",  tx_data, mon_e.d);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              req      data          stall wait drop rst  grant    byte
        vecs[0] = '{4'b0010, 32'h0000A500, 0, 0,  1'b0, 1'b0, 4'b0010, 8'hA5};
        vecs[1] = '{4'b1111, 32'h44332211, 0, 0,  1'b0, 1'b1, 4'b0001, 8'h11};
        vecs[2] = '{4'b1111, 32'h44332211, 0, 0,  1'b0, 1'b0, 4'b0010, 8'h22};
        vecs[3] = '{4'b1111, 32'h44332211, 0, 0,  1'b0, 1'b0, 4'b0100, 8'h33};
        vecs[4] = '{4'b1111, 32'h44332211, 0, 0,  1'b0, 1'b0, 4'b1000, 8'h44};
        vecs[5] = '{4'b1111, 32'h44332211, 0, 0,  1'b0, 1'b0, 4'b0001, 8'h11};
        vecs[6] = '{4'b0001, 32'hDEADBEEF, 0, 2,  1'b1, 1'b0, 4'b0001, 8'hEF};
        vecs[7] = '{4'b1001, 32'h5A3C7E81, 5, 0,  1'b0, 1'b0, 4'b1000, 8'h5A};
        vecs[8] = '{4'b0110, 32'h0F1E2D3C, 0, 15, 1'b1, 1'b0, 4'b0010, 8'h2D};
        vecs[9] = '{4'b0100, 32'hC3B2A190, 0, 3,  1'b0, 1'b0, 4'b0100, 8'hB2};

        // Reset must dominate active inputs.
        reset    = 1'b1;
        req      = 4'hF;
        data_bus = 32'hFFFFFFFF;
        dsr      = 1'b1;
        tx_end   = 1'b1;
        step();
        chk_zero("rst0");
        step();
        chk_zero("rst1");
        reset  = 1'b0;
        req    = 4'd0;
        dsr    = 1'b0;
        tx_end = 1'b0;
        step();
        chk("idle_noreq_grant", grant, 0);
        chk("idle_noreq_busy",  busy,  0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst_first) do_reset();
            do_xfer(vecs[i].req, vecs[i].data, vecs[i].stall, vecs[i].waitc,
                    vecs[i].drop, vecs[i].exp_grant, vecs[i].exp_data);
        end

        // Timeout: 16 WAIT_END cycles without tx_end.
        do_reset();
        mon_e.g = 4'b0100;
        mon_e.d = 8'h66;
        exp_q.push_back(mon_e);
        req      = 4'b0100;
        data_bus = 32'h00660000;
        dsr      = 1'b1;
        step();
        chk("to_load", tx_load, 1);
        req = 4'd0;
        step();
        step();
        chk("to_send", tx_send, 1);
        step();
        for (int w = 0; w < 15; w++) begin
            step();
            chk("to_wait_busy",    busy,    1);
            chk("to_wait_confirm", confirm, 0);
            chk("to_wait_error",   error,   0);
        end
        step();
        chk("to_error",   error,   1);
        chk("to_busy",    busy,    0);
        chk("to_grant",   grant,   0);
        chk("to_confirm", confirm, 0);
        step();
        chk("to_sticky_error", error,   1);
        chk("to_no_confirm",   confirm, 0);
        // Pointer advanced past requester 2, so requester 3 wins next.
        do_xfer(4'hF, 32'h44332211, 0, 0, 1'b0, 4'b1000, 8'h44);

        // Reset during WAIT_END abandons the transfer.
        mon_e.g = 4'b0010;
        mon_e.d = 8'h77;
        exp_q.push_back(mon_e);
        req      = 4'b0010;
        data_bus = 32'h00007700;
        dsr      = 1'b1;
        step();
        chk("rw_load", tx_load, 1);
        req = 4'd0;
        step();
        step();
        step();
        step();
        chk("rw_in_wait_busy", busy, 1);
        reset = 1'b1;
        step();
        chk_zero("rw");
        reset  = 1'b0;
        tx_end = 1'b1;
        step();
        tx_end = 1'b0;
        chk("rw_late_end_confirm", confirm, 0);
        chk("rw_late_end_busy",    busy,    0);
        step();
        chk("rw_idle_grant", grant, 0);
        // Reset returned the pointer to requester 0.
        do_xfer(4'hF, 32'h44332211, 0, 0, 1'b0, 4'b0001, 8'h11);
        req = 4'd0;
        step();
        step();
        chk("sb_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
